call_return_ctrl: RTL

Control-flow sequencer that drives the 5-entry PC/flags call stack from the consumer side. It turns CALL, RET and interrupt-entry requests from the decode stage into correctly timed `push_en`/`pop_en` strobes, and returns the PC/flag reload values to the fetch unit. It tracks occupancy, which the stack does not report, and flags overflow/underflow. After reset it drains the stack, because the stack itself has no reset.

---
 rtl/call_return_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/call_return_ctrl.sv
// Call/return sequencer: turns CALL, RET and IRQ requests into stack push/pop
// strobes and PC/flags redirects, tracks stack occupancy and drains the
// unresettable stack after every reset.
module call_return_ctrl #(
    parameter int unsigned    PC_W       = 9,
    parameter int unsigned    FL_W       = 4,
    parameter int unsigned    DEPTH      = 5,
    parameter logic [PC_W-1:0] IRQ_VECTOR = PC_W'(9'h1F0)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            call_req,
    input  logic [PC_W-1:0] target,
    input  logic            ret_req,
    input  logic            irq_req,
    input  logic            irq_en,
    input  logic [PC_W-1:0] cur_pc,
    input  logic [FL_W-1:0] cur_flags,
    output logic            stk_push_en,
    output logic            stk_pop_en,
    output logic [PC_W-1:0] stk_pc_in,
    output logic [FL_W-1:0] stk_flags_in,
    input  logic [PC_W-1:0] stk_pc_out,
    input  logic [FL_W-1:0] stk_flags_out,
    output logic            pc_load,
    output logic [PC_W-1:0] pc_next,
    output logic            flags_load,
    output logic [FL_W-1:0] flags_next,
    output logic            irq_ack,
    output logic            busy,
    output logic [2:0]      depth,
    output logic            ovf_err,
    output logic            unf_err
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        ST_FLUSH = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ACT   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_CALL = 2'd0,
        OP_IRQ  = 2'd1,
        OP_RET  = 2'd2
    } op_e;

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [2:0]      depth_q, depth_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic [PC_W-1:0] stk_pc_in_q, stk_pc_in_d;
    logic [FL_W-1:0] stk_flags_in_q, stk_flags_in_d;
    logic [PC_W-1:0] pc_next_q, pc_next_d;
    logic [FL_W-1:0] flags_next_q, flags_next_d;

    logic irq_take_c;
    logic full_c;
    logic empty_c;

    assign irq_take_c = irq_req & irq_en;
    assign full_c     = (depth_q == 3'(DEPTH));
    assign empty_c    = (depth_q == 3'd0);

    // State and datapath registers; reset restarts the flush with an empty count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_FLUSH;
            op_q           <= OP_CALL;
            flush_cnt_q    <= '0;
            depth_q        <= '0;
            ovf_q          <= 1'b0;
            unf_q          <= 1'b0;
            stk_pc_in_q    <= '0;
            stk_flags_in_q <= '0;
            pc_next_q      <= '0;
            flags_next_q   <= '0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            flush_cnt_q    <= flush_cnt_d;
            depth_q        <= depth_d;
            ovf_q          <= ovf_d;
            unf_q          <= unf_d;
            stk_pc_in_q    <= stk_pc_in_d;
            stk_flags_in_q <= stk_flags_in_d;
            pc_next_q      <= pc_next_d;
            flags_next_q   <= flags_next_d;
        end
    end

    // Next state: flush count, request arbitration (irq > ret > call), occupancy
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        flush_cnt_d    = flush_cnt_q;
        depth_d        = depth_q;
        ovf_d          = ovf_q;
        unf_d          = unf_q;
        stk_pc_in_d    = stk_pc_in_q;
        stk_flags_in_d = stk_flags_in_q;
        pc_next_d      = pc_next_q;
        flags_next_d   = flags_next_q;

        case (state_q)
            ST_FLUSH: begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
                if (flush_cnt_q == CNT_W'(DEPTH - 1)) begin
                    state_d     = ST_IDLE;
                    flush_cnt_d = '0;
                end
            end
            ST_IDLE: begin
                if (irq_take_c) begin
                    if (full_c) begin
                        ovf_d = 1'b1;
                    end else begin
                        op_d           = OP_IRQ;
                        // Stack adds one on push, so store pc-1 to resume at cur_pc
                        stk_pc_in_d    = cur_pc - PC_W'(1);
                        stk_flags_in_d = cur_flags;
                        pc_next_d      = IRQ_VECTOR;
                        flags_next_d   = '0;
                        state_d        = ST_ACT;
                    end
                end else if (ret_req) begin
                    if (empty_c) begin
                        unf_d = 1'b1;
                    end else begin
                        op_d    = OP_RET;
                        state_d = ST_ACT;
                    end
                end else if (call_req) begin
                    if (full_c) begin
                        ovf_d = 1'b1;
                    end else begin
                        op_d           = OP_CALL;
                        stk_pc_in_d    = cur_pc;
                        stk_flags_in_d = cur_flags;
                        pc_next_d      = target;
                        state_d        = ST_ACT;
                    end
                end
            end
            ST_ACT: begin
                state_d = ST_IDLE;
                if (op_q == OP_RET) begin
                    depth_d = depth_q - 3'd1;
                end else begin
                    depth_d = depth_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_FLUSH;
            end
        endcase
    end

    // Output decode from the registered state; RET forwards the live stack top
    always_comb begin
        stk_push_en = 1'b0;
        stk_pop_en  = 1'b0;
        pc_load     = 1'b0;
        flags_load  = 1'b0;
        irq_ack     = 1'b0;
        pc_next     = pc_next_q;
        flags_next  = flags_next_q;

        case (state_q)
            ST_FLUSH: begin
                stk_pop_en = 1'b1;
            end
            ST_ACT: begin
                pc_load = 1'b1;
                case (op_q)
                    OP_CALL: begin
                        stk_push_en = 1'b1;
                    end
                    OP_IRQ: begin
                        stk_push_en = 1'b1;
                        flags_load  = 1'b1;
                        irq_ack     = 1'b1;
                    end
                    OP_RET: begin
                        stk_pop_en = 1'b1;
                        flags_load = 1'b1;
                        pc_next    = stk_pc_out;
                        flags_next = stk_flags_out;
                    end
                    default: begin
                        pc_load = 1'b0;
                    end
                endcase
            end
            default: begin
            end
        endcase
    end

    assign busy         = (state_q != ST_IDLE);
    assign depth        = depth_q;
    assign ovf_err      = ovf_q;
    assign unf_err      = unf_q;
    assign stk_pc_in    = stk_pc_in_q;
    assign stk_flags_in = stk_flags_in_q;

endmodule
